rotate_right_seq: RTL and testbench
===================================

Name: rotate_right_seq

Overview:
- Multicycle right rotator/shifter for the 16-bit datapath.
- Complements the combinational left barrel rotator. It supplies rotate-right, logical shift-right and arithmetic shift-right.
- Processes one barrel layer per clock: layer k applies a shift of 2^k when ShAmt bit k is set.
- Uses a valid/ready handshake on both input and output, so the control unit can stall around it.

Parameters:
- WIDTH, 16, data width; must equal 2**SHW.
- SHW, 4, shift-amount width; equals the number of barrel layers.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request strobe; accepted only when in_ready=1
- in_ready  output  1  high in IDLE only
- op  input  2  00=ROR, 01=SRL, 10=SRA, 11=reserved (executes as ROR)
- in_data  input  WIDTH  operand
- ShAmt  input  SHW  right shift/rotate amount, 0..WIDTH-1
- out_valid  output  1  result valid; high in DONE only
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result register
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, any state, including mid-RUN): state=IDLE, stage=0, out_data=0, out_valid=0, busy=0, in_ready=1. Internal op and amount latches are cleared to 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_data into out_data (working register), and latch op and ShAmt.
  - stage<=0, then go to RUN.
  - in_valid=0: stay in IDLE.
- RUN (in_ready=0, busy=1), each edge with stage=k:
  - If amt[k]=1, out_data<=out_data shifted right by 2^k.
  - Fill for the vacated top 2^k bits:
    - ROR: the low 2^k bits wrap to the top.
    - SRL: zeros.
    - SRA: copies of out_data[WIDTH-1] (the sign of the working value, equivalent to the original sign).
  - If amt[k]=0, out_data is unchanged.
  - If k==SHW-1, go to DONE; otherwise stage<=k+1.
- DONE:
  - out_valid=1; out_data is held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - in_valid is ignored in RUN and DONE; requests are not queued.
- Latency: a request accepted at edge E0 gives out_valid high after edge E0+SHW (4 cycles for the default).
- Minimum issue interval: SHW+2 cycles, because out_ready is sampled in DONE and the next request is accepted in IDLE.
- Amount 0: result equals in_data for all ops; latency is still SHW.
- Amount WIDTH-1:
  - ROR equals rotate-left by 1.
  - SRL leaves only the original bit 15 in bit 0.
  - SRA gives all sign bits.
- Simultaneous events: the out_ready handshake and a new in_valid in the same cycle do not overlap. The new request waits for IDLE.
- out_data between operations holds the last result until the next accept.

Optional Feature:
- Macro: ROTATE_RIGHT_SEQ_EARLY_DONE_EN.
- Defined: after processing stage k in RUN, if amt[SHW-1:k+1]==0 (or k==SHW-1), go to DONE.
  - Latency = 1 + index of the highest set bit of ShAmt; amount 0 gives latency 1.
  - Results are identical to the non-early build.
- Undefined: latency is fixed at SHW for every amount.

Test Plan:
- ROR, in_data=0x1234, ShAmt=4 -> out_data=0x4123, out_valid rises exactly 4 cycles after accept; busy=1 throughout.
- SRA in_data=0x8000 ShAmt=15 -> 0xFFFF; SRL same inputs -> 0x0001; SRA 0x7FF0 ShAmt=4 -> 0x07FF.
- ROR 0xABCD ShAmt=8 -> 0xCDAB:
  - Hold out_ready=0 for 3 cycles: out_valid stays 1, out_data stays stable.
  - Pulse in_valid with 0xFFFF during DONE: it is ignored.
  - After out_ready=1: in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 during RUN stage 2 -> immediately out_valid=0, busy=0, in_ready=1, out_data=0. A following ROR 0x0001 ShAmt=1 -> 0x8000.
- ShAmt=0, op=11, in_data=0x5A5A -> out_data=0x5A5A:
  - Without the macro: latency 4.
  - With ROTATE_RIGHT_SEQ_EARLY_DONE_EN: latency 1, and ShAmt=2 gives latency 2.
- Sweep all 3 ops × all 16 amounts on 0x8421 and 0xF00F against a reference model; latency is checked per build.

Source files
------------

// File: rtl/rotate_right_seq.sv
// rotate_right_seq: multicycle right rotator / logical / arithmetic shifter.
// One barrel layer is applied per clock: layer k shifts by 2^k when ShAmt[k] is set.
// Valid/ready handshake on input (IDLE only) and output (DONE only).
// Optional build macro ROTATE_RIGHT_SEQ_EARLY_DONE_EN: leave RUN as soon as no
// higher amount bits remain, so latency becomes 1 + index of the highest set bit.
module rotate_right_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   ShAmt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned StgW = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [StgW-1:0] LastStage = StgW'(SHW - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [StgW-1:0]  stage_q, stage_d;
    logic [1:0]       op_q, op_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [WIDTH-1:0]   step;
    logic [2*WIDTH-1:0] rot_wide;
    logic [WIDTH-1:0]   layer_res;
    logic               last_stage;

    // Result of the current barrel layer applied to the working register.
    always_comb begin
        step     = WIDTH'(1) << stage_q;
        rot_wide = {data_q, data_q} >> step;
        case (op_q)
            2'b01:   layer_res = data_q >> step;
            2'b10:   layer_res = $signed(data_q) >>> step;
            default: layer_res = rot_wide[WIDTH-1:0];  // ROR, and reserved 11 behaves as ROR
        endcase
    end

    // Decide whether the current stage is the final one.
    always_comb begin
`ifdef ROTATE_RIGHT_SEQ_EARLY_DONE_EN
        last_stage = (stage_q == LastStage) || (((amt_q >> stage_q) >> 1) == '0);
`else
        last_stage = (stage_q == LastStage);
`endif
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        op_d    = op_q;
        amt_d   = amt_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d  = in_data;
                    op_d    = op;
                    amt_d   = ShAmt;
                    stage_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (amt_q[stage_q]) begin
                    data_d = layer_res;
                end
                if (last_stage) begin
                    state_d = StDone;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            stage_q <= '0;
            op_q    <= '0;
            amt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = data_q;

endmodule

// File: tb/tb_rotate_right_seq.sv
// Self-checking bench for rotate_right_seq: directed vector table, hand-written
// handshake/reset sequences, and a sweep plus random vectors against a bit-level model.
module tb_rotate_right_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SHW   = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   sh_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int n_checks;
    int n_fail;

    rotate_right_seq #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .in_data  (in_data),
        .ShAmt    (sh_amt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [3:0]  amt;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-level reference: output bit i takes source bit i+amt, with op-specific fill.
    function automatic logic [15:0] ref_model(input logic [1:0] o, input logic [15:0] d,
                                              input logic [3:0] a);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            int j;
            j = i + int'(a);
            if (o == 2'b01)      r[i] = (j < 16) ? d[j] : 1'b0;
            else if (o == 2'b10) r[i] = (j < 16) ? d[j] : d[15];
            else                 r[i] = d[j % 16];
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] a);
`ifdef ROTATE_RIGHT_SEQ_EARLY_DONE_EN
        int hi;
        hi = 0;
        for (int i = 0; i < 4; i++) if (a[i]) hi = i;
        return hi + 1;
`else
        return SHW;
`endif
    endfunction

    // Wait (bounded) for in_ready, then present one request for one edge.
    task automatic accept(input logic [1:0] o, input logic [15:0] d, input logic [3:0] a);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        op       = o;
        in_data  = d;
        sh_amt   = a;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid; busy must stay high meanwhile.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] d,
                          input logic [3:0] a, input logic [15:0] exp);
        int lat;
        bit bok;
        accept(o, d, a);
        wait_done(lat, bok);
        chk({nm, "_data"}, 32'(out_data), 32'(exp));
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat(a)));
        chk({nm, "_busy"}, 32'(bok), 32'd1);
        release_result();
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        bit bok;
        logic [15:0] pats[2];
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        in_data   = '0;
        sh_amt    = '0;

        vecs.push_back('{2'b00, 16'h1234, 4'd4,  16'h4123});
        vecs.push_back('{2'b10, 16'h8000, 4'd15, 16'hFFFF});
        vecs.push_back('{2'b01, 16'h8000, 4'd15, 16'h0001});
        vecs.push_back('{2'b10, 16'h7FF0, 4'd4,  16'h07FF});
        vecs.push_back('{2'b11, 16'h5A5A, 4'd0,  16'h5A5A});
        vecs.push_back('{2'b01, 16'h00F0, 4'd2,  16'h003C});
        vecs.push_back('{2'b00, 16'h8001, 4'd15, 16'h0003});

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].exp);
        end

        // Output stall, ignored request during DONE, then release.
        accept(2'b00, 16'hABCD, 4'd8);
        wait_done(lat, bok);
        chk("stall_data", 32'(out_data), 32'h0000CDAB);
        chk("stall_latency", 32'(lat), 32'(exp_lat(4'd8)));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'(out_data), 32'h0000CDAB);
        end
        op       = 2'b00;
        in_data  = 16'hFFFF;
        sh_amt   = 4'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_ignores_in_valid", 32'(out_data), 32'h0000CDAB);
        chk("done_still_valid", 32'(out_valid), 32'd1);
        release_result();
        @(negedge clk);
        chk("idle_holds_result", 32'(out_data), 32'h0000CDAB);
        chk("idle_no_busy", 32'(busy), 32'd0);

        // Asynchronous reset while in RUN stage 2.
        accept(2'b00, 16'h1234, 4'd15);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_reset", 2'b00, 16'h0001, 4'd1, 16'h8000);

        // Sweep every op and amount on two patterns.
        pats[0] = 16'h8421;
        pats[1] = 16'hF00F;
        for (int p = 0; p < 2; p++) begin
            for (int o = 0; o < 3; o++) begin
                for (int a = 0; a < 16; a++) begin
                    run_op($sformatf("sweep_p%0d_op%0d_a%0d", p, o, a), 2'(o), pats[p], 4'(a),
                           ref_model(2'(o), pats[p], 4'(a)));
                end
            end
        end

        // Random operands, including the reserved op code.
        for (int n = 0; n < 24; n++) begin
            logic [1:0]  ro;
            logic [15:0] rd;
            logic [3:0]  ra;
            ro = 2'($urandom_range(0, 3));
            rd = 16'($urandom);
            ra = 4'($urandom_range(0, 15));
            run_op($sformatf("rand%0d", n), ro, rd, ra, ref_model(ro, rd, ra));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
